regfile_writeback_queue: RTL

- Write-side initiator for the 8x8 register file: buffers register writebacks from the ALU/memory stage and drains them into the register file's single write port, one per cycle.
- Provides read bypass so decode sees pending (queued, not yet committed) values.
- Sits between the execute/memory stage and the register file.
- Register 0 is hard-wired zero: writes to it are accepted and discarded; reads of it return 0.

---
 rtl/regfile_writeback_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the register file's single write port.
// Buffers accepted writes, commits them in order, and forwards pending values to decode.
module regfile_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       drain_en,
  output logic [ADDR_W-1:0]          rf_reg_write,
  output logic                       rf_reg_write_signal,
  output logic [DATA_W-1:0]          rf_in_data,
  input  logic [ADDR_W-1:0]          rd_addr_1,
  input  logic [ADDR_W-1:0]          rd_addr_2,
  input  logic [DATA_W-1:0]          rf_data_1,
  input  logic [DATA_W-1:0]          rf_data_2,
  output logic [DATA_W-1:0]          fwd_data_1,
  output logic [DATA_W-1:0]          fwd_data_2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign wb_ready = !full;
  assign count    = count_q;

  // Writes to R0 complete the handshake but never occupy an entry.
  assign push = wb_valid && !full && (wb_addr != '0);
  assign pop  = !empty && drain_en;

  assign rf_reg_write_signal = pop;
  assign rf_reg_write        = empty ? '0 : addr_q[head_q];
  assign rf_in_data          = empty ? '0 : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wb_addr;
      data_q[tail_q] <= wb_data;
    end
  end

  // Walk oldest to youngest so the newest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_data_1 = rf_data_1;
    fwd_data_2 = rf_data_2;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (addr_q[idx] == rd_addr_1) fwd_data_1 = data_q[idx];
        if (addr_q[idx] == rd_addr_2) fwd_data_2 = data_q[idx];
      end
    end
    if (rd_addr_1 == '0) fwd_data_1 = '0;
    if (rd_addr_2 == '0) fwd_data_2 = '0;
  end

endmodule
